clock_period_meter: RTL and testbench

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_period_meter.sv | 138 +++++++++++++
 tb/tb_clock_period_meter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - measures sig_in period in clk_in cycles and recovers scale = period/CONST
// Optional stall detection compiled in with `define CLKMETER_TIMEOUT_EN.
module clock_period_meter #(
  parameter int WIDTH   = 8,
  parameter int CONST   = 258850,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 67108864
) (
  input  logic             clk_in,
  input  logic             nrst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [WIDTH-1:0] scale_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun,
  output logic             stalled
);

  localparam int DW = CNT_W + WIDTH;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] CONST_W = DW'(CONST);
  localparam logic [DW-1:0] LIMIT   = CONST_W << WIDTH;

  typedef enum logic [1:0] {ARM, MEASURE, DIVIDE} state_t;

  state_t           state, state_next;
  logic             sync1, sync2, sync3, rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] p_meas;
  logic [CNT_W-1:0] p_reg;
  logic [DW-1:0]    rem;
  logic [DW-1:0]    trial;
  logic [WIDTH-1:0] quo, q_next;
  logic [IW-1:0]    idx;
  logic             sat;
  logic             ge;
  logic             time_hit;
  logic             last_step;

  assign p_meas    = (&cnt) ? cnt : cnt + 1'b1;
  assign trial     = CONST_W << idx;
  assign ge        = (rem >= trial);
  assign last_step = (idx == '0);
  assign busy      = (state == DIVIDE);

  always_comb begin
    q_next = quo;
    if (ge) q_next[idx] = 1'b1;
  end

`ifdef CLKMETER_TIMEOUT_EN
  assign time_hit = (cnt == CNT_W'(TIMEOUT - 1)) && !rise;

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst)         stalled <= 1'b0;
    else if (time_hit) stalled <= 1'b1;
    else if (rise)     stalled <= 1'b0;
  end
`else
  wire unused_timeout = |TIMEOUT;
  assign time_hit = 1'b0;
  assign stalled  = 1'b0;
`endif

  // Two sync flops, then an edge-detect flop whose output is the registered rise pulse.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      sync3 <= sync2;
      rise  <= sync2 & ~sync3;
    end
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst)      cnt <= '0;
    else if (rise)  cnt <= '0;
    else if (!(&cnt)) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) state <= ARM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARM:     if (rise) state_next = MEASURE;
      MEASURE: if (rise) state_next = DIVIDE;
      DIVIDE:  if (last_step) state_next = MEASURE;
      default: state_next = ARM;
    endcase
    if (time_hit) state_next = ARM;
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      p_reg      <= '0;
      rem        <= '0;
      quo        <= '0;
      idx        <= '0;
      sat        <= 1'b0;
      period_out <= '0;
      scale_out  <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == MEASURE && rise && !time_hit) begin
        p_reg <= p_meas;
        rem   <= {{WIDTH{1'b0}}, p_meas};
        quo   <= '0;
        idx   <= IW'(WIDTH - 1);
        sat   <= ({{WIDTH{1'b0}}, p_meas} >= LIMIT);
      end
      if (state == DIVIDE) begin
        // Restoring step still runs when saturated so latency stays fixed at WIDTH cycles.
        if (ge) rem <= rem - trial;
        quo <= q_next;
        idx <= idx - 1'b1;
        if (last_step && !time_hit) begin
          period_out <= p_reg;
          scale_out  <= sat ? {WIDTH{1'b1}} : q_next;
          valid      <= 1'b1;
        end
        if (rise) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - scoreboard bench for clock_period_meter (CONST=10, WIDTH=8, TIMEOUT=1000)
module tb_clock_period_meter;

  localparam int WIDTH   = 8;
  localparam int CONST   = 10;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 1000;
  // sig_in driven at negedge before edge k; capture at k+3, valid visible after edge k+11.
  localparam int LAT     = 12;

  logic             clk_in = 1'b0;
  logic             nrst   = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic [WIDTH-1:0] scale_out;
  logic             valid, busy, overrun, stalled;

  clock_period_meter #(
    .WIDTH(WIDTH), .CONST(CONST), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk_in), .nrst(nrst), .sig_in(sig_in),
    .period_out(period_out), .scale_out(scale_out),
    .valid(valid), .busy(busy), .overrun(overrun), .stalled(stalled)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int period;
    int scale;
    int due;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   armed    = 1'b0;
  int   last_e   = 0;
  int   cap_e    = -1000;
  bit   exp_ovr  = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input int e);
    exp_t x;
    int   gap;
    gap = e - last_e;
`ifdef CLKMETER_TIMEOUT_EN
    if (armed && gap > TIMEOUT) armed = 1'b0;
`endif
    if (!armed) begin
      armed = 1'b1;
      cap_e = -1000;
    end else if (e - cap_e <= WIDTH) begin
      exp_ovr = 1'b1;
    end else begin
      x.period = gap;
      x.scale  = (gap / CONST > 255) ? 255 : gap / CONST;
      x.due    = e + LAT;
      q.push_back(x);
      cap_e = e;
    end
    last_e = e;
  endtask

  task automatic pulse_train(input int period, input int n);
    int h;
    h = period / 2;
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      model_edge(cyc);
      repeat (h) @(negedge clk_in);
      sig_in = 1'b0;
      repeat (period - h) @(negedge clk_in);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"},  period_out, 0);
    check({tag, "_scale"},   scale_out,  0);
    check({tag, "_valid"},   valid,      0);
    check({tag, "_busy"},    busy,       0);
    check({tag, "_overrun"}, overrun,    0);
    check({tag, "_stalled"}, stalled,    0);
  endtask

  always @(posedge clk_in) begin
    exp_t x;
    #1;
    if (nrst && valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        x = q.pop_front();
        check("period_out", period_out, x.period);
        check("scale_out", scale_out, x.scale);
        check("valid_cycle", cyc, x.due);
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk_in);
    $display("FAIL watchdog: cycle budget exhausted at %0d, required finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    repeat (3) @(negedge clk_in);
    check_zero("reset");
    nrst = 1'b1;
    repeat (5) @(negedge clk_in);

    pulse_train(30, 6);
    check("overrun_idle", overrun, exp_ovr);
    pulse_train(5000, 2);
    pulse_train(7, 6);
    check("overrun_set", overrun, exp_ovr);
    pulse_train(30, 3);
    check("overrun_sticky", overrun, 1);

    // Reset four cycles into a running division.
    sig_in = 1'b1;
    model_edge(cyc);
    e = cyc;
    repeat (4) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (4) @(negedge clk_in);
    check("busy_in_divide", busy, 1);
    nrst = 1'b0;
    armed = 1'b0;
    exp_ovr = 1'b0;
    q.delete();
    repeat (4) @(negedge clk_in);
    check_zero("mid_reset");
    nrst = 1'b1;
    repeat (20) @(negedge clk_in);
    check_zero("post_reset");
    last_e = cyc;
    pulse_train(30, 4);

    // Long gap after a steady train.
    pulse_train(30, 2);
    sig_in = 1'b1;
    model_edge(cyc);
    e = cyc;
    repeat (15) @(negedge clk_in);
    sig_in = 1'b0;
    while (cyc < e + 1100) @(negedge clk_in);
`ifdef CLKMETER_TIMEOUT_EN
    check("stalled_set", stalled, 1);
`else
    check("stalled_never", stalled, 0);
`endif
    while (cyc < e + 1200) @(negedge clk_in);
    sig_in = 1'b1;
    model_edge(cyc);
    repeat (15) @(negedge clk_in);
    sig_in = 1'b0;
    check("stalled_clear", stalled, 0);
    repeat (15) @(negedge clk_in);
    pulse_train(30, 3);

    repeat (40) @(negedge clk_in);
    check("queue_drained", q.size(), 0);
    check("busy_final", busy, 0);
    check("overrun_final", overrun, exp_ovr);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
